// File: rtl/rx_hs_fsm.sv
// D-PHY HS receive FSM: leader/sync detection, payload delivery through a trail-length delay line.
// Optional saturating error counter enabled by `define RX_HS_ERR_CNT_EN.
module rx_hs_fsm #(
   parameter int unsigned T_HS_ZERO_MIN = 2,
   parameter int unsigned T_HS_TRAIL    = 4,
   parameter logic [7:0]  SYNC_BYTE     = 8'h1D
) (
   input  logic       TX_DDR_clk,
   input  logic       TX_rst,
   input  logic       Enable,
   input  logic [7:0] RX_BYTE_IN,
   input  logic       RX_BYTE_IN_VALID,
   output logic [2:0] RX_HS_STATE,
   output logic [7:0] RX_BYTE_DATA,
   output logic       RX_BYTE_DATA_VALID,
   output logic       RX_HS_ACTIVE,
   output logic       RX_HS_END,
   output logic       RX_SYNC_ERR,
   output logic       RX_TRAIL_ERR,
   output logic [7:0] RX_ERR_COUNT
);

   localparam int unsigned ZW = $clog2(T_HS_ZERO_MIN + 1);
   localparam int unsigned FW = $clog2(T_HS_TRAIL + 1);
   localparam logic [ZW-1:0] ZERO_MAX  = ZW'(T_HS_ZERO_MIN);
   localparam logic [FW-1:0] FILL_FULL = FW'(T_HS_TRAIL);

   typedef enum logic [2:0] {
      STOP  = 3'b000,
      ZERO  = 3'b001,
      DATA  = 3'b011,
      TRAIL = 3'b100,
      ERR   = 3'b101
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [ZW-1:0]   r_zero_cnt;
   logic [ZW-1:0]   w_zero_nxt;
   logic [FW-1:0]   r_fill;
   logic [7:0]      r_buf [T_HS_TRAIL];
   logic [7:0]      r_data;
   logic            r_data_valid;
   logic            r_end;
   logic            r_sync_err;
   logic            r_trail_err;
   logic            w_shift;
   logic            w_emit;
   logic            w_end_nxt;
   logic            w_sync_err_nxt;
   logic            w_trail_err_nxt;
   logic            w_trail_bad;

   // Trail is good only when the line is full and every buffered byte is 0xFF.
   always_comb begin
      w_trail_bad = (r_fill != FILL_FULL);
      for (int unsigned i = 0; i < T_HS_TRAIL; i++) begin
         if (r_buf[i] != 8'hFF) w_trail_bad = 1'b1;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_zero_nxt      = r_zero_cnt;
      w_shift         = 1'b0;
      w_emit          = 1'b0;
      w_end_nxt       = 1'b0;
      w_sync_err_nxt  = 1'b0;
      w_trail_err_nxt = 1'b0;
      if (!Enable) begin
         w_state_nxt = STOP;
      end else begin
         case (r_state)
            STOP: begin
               if (RX_BYTE_IN_VALID) begin
                  if (RX_BYTE_IN == 8'h00) begin
                     w_state_nxt = ZERO;
                     w_zero_nxt  = ZW'(1);
                  end else begin
                     w_state_nxt    = ERR;
                     w_sync_err_nxt = 1'b1;
                  end
               end
            end
            ZERO: begin
               if (!RX_BYTE_IN_VALID) begin
                  w_state_nxt = STOP;
               end else if (RX_BYTE_IN == 8'h00) begin
                  if (r_zero_cnt != ZERO_MAX) w_zero_nxt = r_zero_cnt + ZW'(1);
               end else if (RX_BYTE_IN == SYNC_BYTE && r_zero_cnt >= ZERO_MAX) begin
                  w_state_nxt = DATA;
               end else begin
                  w_state_nxt    = ERR;
                  w_sync_err_nxt = 1'b1;
               end
            end
            DATA: begin
               if (!RX_BYTE_IN_VALID) begin
                  w_state_nxt     = TRAIL;
                  w_end_nxt       = 1'b1;
                  w_trail_err_nxt = w_trail_bad;
               end else begin
                  w_shift = 1'b1;
                  w_emit  = (r_fill == FILL_FULL);
               end
            end
            TRAIL: w_state_nxt = STOP;
            ERR: begin
               if (!RX_BYTE_IN_VALID) w_state_nxt = STOP;
            end
            default: w_state_nxt = STOP;
         endcase
      end
      if (w_state_nxt != ZERO) w_zero_nxt = '0;
   end

   always_ff @(posedge TX_DDR_clk or posedge TX_rst) begin
      if (TX_rst) begin
         r_state      <= STOP;
         r_zero_cnt   <= '0;
         r_fill       <= '0;
         r_data       <= '0;
         r_data_valid <= 1'b0;
         r_end        <= 1'b0;
         r_sync_err   <= 1'b0;
         r_trail_err  <= 1'b0;
         for (int unsigned i = 0; i < T_HS_TRAIL; i++) r_buf[i] <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_zero_cnt   <= w_zero_nxt;
         r_data_valid <= w_emit;
         r_end        <= w_end_nxt;
         r_sync_err   <= w_sync_err_nxt;
         r_trail_err  <= w_trail_err_nxt;
         if (w_emit) r_data <= r_buf[T_HS_TRAIL-1];
         // Line contents only live while in DATA; leaving it discards them.
         if (w_state_nxt != DATA) begin
            r_fill <= '0;
            for (int unsigned i = 0; i < T_HS_TRAIL; i++) r_buf[i] <= '0;
         end else if (w_shift) begin
            if (r_fill != FILL_FULL) r_fill <= r_fill + FW'(1);
            for (int unsigned i = T_HS_TRAIL - 1; i > 0; i--) r_buf[i] <= r_buf[i-1];
            r_buf[0] <= RX_BYTE_IN;
         end
      end
   end

   assign RX_HS_STATE        = r_state;
   assign RX_HS_ACTIVE       = (r_state == DATA);
   assign RX_BYTE_DATA       = r_data;
   assign RX_BYTE_DATA_VALID = r_data_valid;
   assign RX_HS_END          = r_end;
   assign RX_SYNC_ERR        = r_sync_err;
   assign RX_TRAIL_ERR       = r_trail_err;

`ifdef RX_HS_ERR_CNT_EN
   logic [7:0] r_err_cnt;

   always_ff @(posedge TX_DDR_clk or posedge TX_rst) begin
      if (TX_rst) begin
         r_err_cnt <= '0;
      end else if ((w_sync_err_nxt || w_trail_err_nxt) && r_err_cnt != 8'hFF) begin
         r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   assign RX_ERR_COUNT = r_err_cnt;
`else
   assign RX_ERR_COUNT = '0;
`endif

endmodule

// File: tb/tb_rx_hs_fsm.sv
// Directed self-checking bench for rx_hs_fsm: nominal, 0xFF payload, sync/trail errors, abort, reset.
module tb_rx_hs_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       vld;
   logic [7:0] bin;
   logic [2:0] st;
   logic [7:0] dout;
   logic       dval;
   logic       act;
   logic       hend;
   logic       serr;
   logic       terr;
   logic [7:0] ecnt;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   int         cyc;
   logic [7:0] q_data[$];
   int         q_dcyc[$];
   int         n_end;
   int         n_serr;
   int         n_terr;
   int         end_cyc;

   rx_hs_fsm #(
      .T_HS_ZERO_MIN(2),
      .T_HS_TRAIL(4),
      .SYNC_BYTE(8'h1D)
   ) dut (
      .TX_DDR_clk(clk),
      .TX_rst(rst),
      .Enable(en),
      .RX_BYTE_IN(bin),
      .RX_BYTE_IN_VALID(vld),
      .RX_HS_STATE(st),
      .RX_BYTE_DATA(dout),
      .RX_BYTE_DATA_VALID(dval),
      .RX_HS_ACTIVE(act),
      .RX_HS_END(hend),
      .RX_SYNC_ERR(serr),
      .RX_TRAIL_ERR(terr),
      .RX_ERR_COUNT(ecnt)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, summary not printed");
      $fatal(1, "watchdog");
   end

   task automatic clear_obs();
      cyc     = 0;
      q_data.delete();
      q_dcyc.delete();
      n_end   = 0;
      n_serr  = 0;
      n_terr  = 0;
      end_cyc = -1;
   endtask

   // One byte-clock cycle: drive on the falling edge, observe 1ns after the rising edge.
   task automatic step(input logic v, input logic [7:0] b);
      @(negedge clk);
      vld = v;
      bin = b;
      @(posedge clk);
      #1;
      cyc++;
      if (dval === 1'b1) begin
         q_data.push_back(dout);
         q_dcyc.push_back(cyc);
      end
      if (hend === 1'b1) begin
         n_end++;
         end_cyc = cyc;
      end
      if (serr === 1'b1) n_serr++;
      if (terr === 1'b1) n_terr++;
   endtask

   task automatic send(input logic [127:0] v, input int n);
      for (int i = 0; i < n; i++) step(1'b1, v[8*(n-1-i) +: 8]);
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; vld = 1'b0; bin = 8'h00;
      #12;
      n_tests++; if (st !== 3'b000) begin n_fail++; $display("FAIL rst_state: got %b exp 000", st); end
      n_tests++; if (dout !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h exp 00", dout); end
      n_tests++; if ({dval, hend, serr, terr} !== 4'b0000) begin n_fail++; $display("FAIL rst_pulses: got %b exp 0000", {dval, hend, serr, terr}); end
      n_tests++; if (act !== 1'b0) begin n_fail++; $display("FAIL rst_active: got %b exp 0", act); end
      n_tests++; if (ecnt !== 8'h00) begin n_fail++; $display("FAIL rst_errcnt: got %h exp 00", ecnt); end
      @(negedge clk);
      rst = 1'b0;
      en  = 1'b1;
   endtask

   task automatic test_nominal();
      logic [23:0] exp_d;
      exp_d = 24'hA1A2A3;
      clear_obs();
      send(128'h000000001D, 5);
      n_tests++; if (st !== 3'b011) begin n_fail++; $display("FAIL nom_state_data: got %b exp 011", st); end
      n_tests++; if (act !== 1'b1) begin n_fail++; $display("FAIL nom_active: got %b exp 1", act); end
      send(128'hA1A2A3FFFFFFFF, 7);
      step(1'b0, 8'h00);
      n_tests++; if (st !== 3'b100) begin n_fail++; $display("FAIL nom_state_trail: got %b exp 100", st); end
      n_tests++; if ({hend, terr, act} !== 3'b100) begin n_fail++; $display("FAIL nom_trail_flags: got end/terr/act %b exp 100", {hend, terr, act}); end
      step(1'b0, 8'h00);
      n_tests++; if ({st, hend} !== 4'b0000) begin n_fail++; $display("FAIL nom_back_stop: got state/end %b exp 0000", {st, hend}); end
      n_tests++;
      if (q_data.size() != 3) begin
         n_fail++; $display("FAIL nom_count: got %0d bytes exp 3", q_data.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_tests++; if (q_data[i] !== exp_d[8*(2-i) +: 8]) begin n_fail++; $display("FAIL nom_byte%0d: got %h exp %h", i, q_data[i], exp_d[8*(2-i) +: 8]); end
            n_tests++; if (q_dcyc[i] != 10 + i) begin n_fail++; $display("FAIL nom_latency%0d: got cycle %0d exp %0d", i, q_dcyc[i], 10 + i); end
         end
      end
      n_tests++; if (n_end != 1 || end_cyc != 13) begin n_fail++; $display("FAIL nom_end: got %0d pulses at %0d exp 1 at 13", n_end, end_cyc); end
      n_tests++; if (n_serr + n_terr != 0) begin n_fail++; $display("FAIL nom_errors: got %0d exp 0", n_serr + n_terr); end
   endtask

   task automatic test_ff_payload();
      clear_obs();
      send(128'h00001DFF11FFFFFFFF, 9);
      step(1'b0, 8'h00);
      step(1'b0, 8'h00);
      n_tests++;
      if (q_data.size() != 2) begin
         n_fail++; $display("FAIL ff_count: got %0d bytes exp 2", q_data.size());
      end else begin
         n_tests++; if (q_data[0] !== 8'hFF || q_dcyc[0] != 8) begin n_fail++; $display("FAIL ff_byte0: got %h at %0d exp FF at 8", q_data[0], q_dcyc[0]); end
         n_tests++; if (q_data[1] !== 8'h11 || q_dcyc[1] != 9) begin n_fail++; $display("FAIL ff_byte1: got %h at %0d exp 11 at 9", q_data[1], q_dcyc[1]); end
      end
      n_tests++; if (n_end != 1) begin n_fail++; $display("FAIL ff_end: got %0d exp 1", n_end); end
      n_tests++; if (n_terr != 0) begin n_fail++; $display("FAIL ff_trail_err: got %0d exp 0", n_terr); end
   endtask

   task automatic test_bad_sync();
      clear_obs();
      send(128'h00005A, 3);
      n_tests++; if ({st, serr} !== 4'b1011) begin n_fail++; $display("FAIL bs_enter: got state/serr %b exp 1011", {st, serr}); end
      step(1'b1, 8'h00);
      n_tests++; if ({st, serr} !== 4'b1010) begin n_fail++; $display("FAIL bs_hold: got state/serr %b exp 1010", {st, serr}); end
      send(128'h001DA1A2A3A4A5, 7);
      n_tests++; if (st !== 3'b101) begin n_fail++; $display("FAIL bs_stay_err: got %b exp 101", st); end
      step(1'b0, 8'h00);
      n_tests++; if (st !== 3'b000) begin n_fail++; $display("FAIL bs_stop: got %b exp 000", st); end
      n_tests++; if (q_data.size() != 0) begin n_fail++; $display("FAIL bs_no_data: got %0d bytes exp 0", q_data.size()); end
      n_tests++; if (n_serr != 1 || n_end != 0) begin n_fail++; $display("FAIL bs_pulses: got serr %0d end %0d exp 1 0", n_serr, n_end); end
   endtask

   task automatic test_short_leader();
      clear_obs();
      send(128'h001D, 2);
      n_tests++; if ({st, serr} !== 4'b1011) begin n_fail++; $display("FAIL sl_err: got state/serr %b exp 1011", {st, serr}); end
      step(1'b0, 8'h00);
      send(128'h0000, 2);
      n_tests++; if (st !== 3'b001) begin n_fail++; $display("FAIL sl_zero: got %b exp 001", st); end
      step(1'b0, 8'h00);
      n_tests++; if ({st, serr, hend} !== 5'b00000) begin n_fail++; $display("FAIL sl_silent_stop: got %b exp 00000", {st, serr, hend}); end
      send(128'h77, 1);
      n_tests++; if ({st, serr} !== 4'b1011) begin n_fail++; $display("FAIL sl_stop_nonzero: got state/serr %b exp 1011", {st, serr}); end
      step(1'b0, 8'h00);
      n_tests++; if (n_serr != 2) begin n_fail++; $display("FAIL sl_serr_count: got %0d exp 2", n_serr); end
   endtask

   task automatic test_short_trail();
      clear_obs();
      send(128'h00001DA1A2FFFF, 7);
      step(1'b0, 8'h00);
      n_tests++; if ({st, hend, terr} !== 5'b10011) begin n_fail++; $display("FAIL st_flags: got state/end/terr %b exp 10011", {st, hend, terr}); end
      step(1'b0, 8'h00);
      n_tests++; if ({st, terr} !== 4'b0000) begin n_fail++; $display("FAIL st_clear: got state/terr %b exp 0000", {st, terr}); end
      n_tests++; if (q_data.size() != 0) begin n_fail++; $display("FAIL st_no_data: got %0d bytes exp 0", q_data.size()); end
   endtask

   task automatic test_abort();
      clear_obs();
      send(128'h00001DA1A2A3A4A5, 8);
      n_tests++; if ({dval, dout} !== 9'h1A1) begin n_fail++; $display("FAIL ab_first: got valid/data %h exp 1A1", {dval, dout}); end
      en = 1'b0;
      step(1'b1, 8'hA6);
      n_tests++; if ({st, act, dval} !== 5'b00000) begin n_fail++; $display("FAIL ab_stop: got %b exp 00000", {st, act, dval}); end
      step(1'b0, 8'h00);
      en = 1'b1;
      step(1'b0, 8'h00);
      step(1'b0, 8'h00);
      n_tests++; if (n_end != 0 || n_terr != 0) begin n_fail++; $display("FAIL ab_no_pulse: got end %0d terr %0d exp 0 0", n_end, n_terr); end
      clear_obs();
      send(128'h00001DB1FFFFFFFF, 8);
      step(1'b0, 8'h00);
      n_tests++;
      if (q_data.size() != 1) begin
         n_fail++; $display("FAIL ab_next_count: got %0d bytes exp 1", q_data.size());
      end else begin
         n_tests++; if (q_data[0] !== 8'hB1 || q_dcyc[0] != 8) begin n_fail++; $display("FAIL ab_next_byte: got %h at %0d exp B1 at 8", q_data[0], q_dcyc[0]); end
      end
      n_tests++; if (n_end != 1 || n_terr != 0) begin n_fail++; $display("FAIL ab_next_end: got end %0d terr %0d exp 1 0", n_end, n_terr); end
      step(1'b0, 8'h00);
   endtask

   task automatic test_reset_mid();
      clear_obs();
      send(128'h00001DC1C2C3C4C5, 8);
      #2;
      rst = 1'b1;
      #1;
      n_tests++; if ({st, act} !== 4'b0000) begin n_fail++; $display("FAIL rm_state: got state/act %b exp 0000", {st, act}); end
      n_tests++; if ({dval, dout} !== 9'h000) begin n_fail++; $display("FAIL rm_data: got valid/data %h exp 000", {dval, dout}); end
      n_tests++; if (ecnt !== 8'h00) begin n_fail++; $display("FAIL rm_errcnt: got %h exp 00", ecnt); end
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 8'h00);
      n_tests++; if ({st, dval} !== 4'b0000) begin n_fail++; $display("FAIL rm_after: got state/valid %b exp 0000", {st, dval}); end
   endtask

   task automatic test_err_count();
`ifdef RX_HS_ERR_CNT_EN
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 300; i++) begin
         step(1'b1, 8'h5A);
         step(1'b0, 8'h00);
         if (i == 0) begin
            n_tests++; if (ecnt !== 8'h01) begin n_fail++; $display("FAIL ec_first: got %h exp 01", ecnt); end
         end
      end
      n_tests++; if (ecnt !== 8'hFF) begin n_fail++; $display("FAIL ec_saturate: got %h exp FF", ecnt); end
`else
      step(1'b1, 8'h5A);
      step(1'b0, 8'h00);
      n_tests++; if (ecnt !== 8'h00) begin n_fail++; $display("FAIL ec_tied: got %h exp 00", ecnt); end
`endif
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_ff_payload();
      test_bad_sync();
      test_short_leader();
      test_short_trail();
      test_abort();
      test_reset_mid();
      test_err_count();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
